boundary_strip: RTL and testbench
=================================

// Module: boundary_strip
// PURPOSE
//  Receive-side counterpart of the filter-input boundary inserter. Consumes the padded pixel
//  stream coming out of the filter stage: widthWithBoundary columns x heightWithBoundary rows,
//  including zero boundary columns and rows. Discards all boundary pixels and emits only the
//  width x height interior pixels, tagged with X/Y coordinates. Pulses done once per frame.
//  Sits between the filter and the rgb2ycc stage / frame-buffer writer.
// PARAMETERS
//  width       320  interior pixels per row
//  height      240  interior rows per frame
//  kernelSize  7    filter kernel size, odd and >=1
//  derived: bw = (kernelSize-1)/2; W = width+kernelSize-1; H = height+kernelSize-1
// PORTS
//  clk         in   1   clock; all logic on posedge
//  reset       in   1   asynchronous, active-high reset
//  newFrame    in   1   synchronous frame restart, 1-cycle pulse
//  iValid      in   1   input beat qualifier; no backpressure
//  iData       in   24  padded-stream pixel {R,G,B}
//  oValid      out  1   interior pixel valid
//  oData       out  24  interior pixel {R,G,B}
//  oX          out  16  interior column, 0..width-1
//  oY          out  16  interior row, 0..height-1
//  oDone       out  1   1-cycle pulse, frame fully consumed
//  oBusy       out  1   frame in progress (state ACTIVE)
//  oPixelCnt   out  32  interior pixels emitted in current/last frame
//  oShortFrame out  1   sticky: frame truncated by newFrame
// BEHAVIOUR
//  - Reset, async: all outputs 0, state IDLE, inCol=inRow=0.
//  - States:
//    - IDLE: the first iValid beat is input index 0. It is processed that cycle; go to ACTIVE.
//    - ACTIVE: process each iValid beat. On the last beat (inCol==W-1 && inRow==H-1),
//      go to IDLE and pulse oDone next cycle.
//  - Per accepted beat:
//    - inCol advances; wraps W-1 -> 0 and increments inRow.
//    - inRow wraps H-1 -> 0 at frame end.
//    - iValid=0 cycles: counters hold, oValid=0. Gaps of any length are legal.
//  - Keep rule: keep the beat iff bw <= inCol < bw+width AND bw <= inRow < bw+height.
//    Other beats are dropped silently.
//  - Output timing: registered, latency exactly 1 cycle.
//    - oValid=1 the cycle after a kept beat, else 0.
//    - oData = iData, oX = inCol-bw, oY = inRow-bw. oData/oX/oY hold when oValid=0.
//  - oPixelCnt: increments with every oValid and clears at the first beat of a new frame.
//    It therefore reads width*height from the oDone pulse until the next frame starts.
//  - oDone: asserted 1 cycle after the final padded beat, the trailing boundary row.
//    This is not the last kept beat.
//  - newFrame: counters clear and state goes to IDLE.
//    - If the state was ACTIVE, set oShortFrame; it clears only on reset.
//    - If iValid is high in the same cycle, newFrame wins and that beat is index 0 of the
//      new frame.
//    - oValid=0 and no oDone in the following cycle unless the new beat 0 is kept
//      (only when bw=0).
//  - kernelSize=1: bw=0 and every beat passes. Each output equals its input delayed by 1.
//  - Back-to-back frames: a beat in the cycle after the final beat starts the next frame
//    with no bubble required.
//  - Coordinate compares use 16-bit unsigned values; width and height must be < 65536.
// TESTING  (width=4, height=3, kernelSize=3 -> W=6, H=5, 30 beats/frame)
//  1. 30 contiguous beats, iData = beat index -> 12 oValid.
//     First is oData=7, oX=0, oY=0. Last is oData=22, oX=3, oY=2.
//     oDone one cycle after beat 29. oPixelCnt=12.
//  2. Same frame with a random 0-3 cycle iValid gap after each beat -> identical
//     oData/oX/oY sequence. oDone is still 1 cycle after the final beat.
//  3. newFrame after beat 10, then a full frame -> oShortFrame=1.
//     The new frame yields 12 pixels starting at its own beat 7. oPixelCnt=12 at oDone.
//  4. Async reset asserted mid-beat 15 -> outputs 0 immediately.
//     The next frame behaves exactly as in test 1.
//  5. Two frames with no gap -> 24 oValid and two oDone pulses 30 cycles apart.
//  6. kernelSize=1, width=4, height=3, 12 beats -> every beat is output 1 cycle later.
//     oX cycles 0..3 and oY 0..2. oDone after beat 11.

Source files
------------

// File: rtl/boundary_strip_if.sv
// Stream/status bundle between the filter stage and boundary_strip.
// slave is the stripper's view; master is the upstream/downstream view.
interface boundary_strip_if;
    logic        newFrame;
    logic        iValid;
    logic [23:0] iData;
    logic        oValid;
    logic [23:0] oData;
    logic [15:0] oX;
    logic [15:0] oY;
    logic        oDone;
    logic        oBusy;
    logic [31:0] oPixelCnt;
    logic        oShortFrame;

    modport master (
        output newFrame, iValid, iData,
        input  oValid, oData, oX, oY, oDone, oBusy, oPixelCnt, oShortFrame
    );

    modport slave (
        input  newFrame, iValid, iData,
        output oValid, oData, oX, oY, oDone, oBusy, oPixelCnt, oShortFrame
    );
endinterface

// File: rtl/boundary_strip.sv
// Strips the zero boundary ring from a padded filter output stream and emits
// interior pixels with X/Y coordinates, one registered cycle after input.
module boundary_strip #(
    parameter int unsigned width      = 320,
    parameter int unsigned height     = 240,
    parameter int unsigned kernelSize = 7
) (
    input  logic             clk,
    input  logic             reset,
    boundary_strip_if.slave  bus
);
    localparam int unsigned BW = (kernelSize - 1) / 2;
    localparam int unsigned W  = width + kernelSize - 1;
    localparam int unsigned H  = height + kernelSize - 1;

    localparam logic [15:0] BW16     = 16'(BW);
    localparam logic [15:0] WIDTH16  = 16'(width);
    localparam logic [15:0] HEIGHT16 = 16'(height);
    localparam logic [15:0] COL_LAST = 16'(W - 1);
    localparam logic [15:0] ROW_LAST = 16'(H - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t      r_state;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic        r_valid;
    logic [23:0] r_data;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_done;
    logic [31:0] r_pixel_cnt;
    logic        r_short;

    state_t      w_state;
    logic [15:0] w_col;
    logic [15:0] w_row;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_keep;
    logic        w_last;
    logic        w_first;

    // newFrame takes effect before the same-cycle beat, so that beat becomes index 0.
    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        if (bus.newFrame) begin
            w_state = IDLE;
            w_col   = '0;
            w_row   = '0;
        end
        // Columns/rows left of the boundary wrap to huge values and fail the range test.
        w_x     = w_col - BW16;
        w_y     = w_row - BW16;
        w_keep  = bus.iValid && (w_x < WIDTH16) && (w_y < HEIGHT16);
        w_last  = (w_col == COL_LAST) && (w_row == ROW_LAST);
        w_first = (w_state == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_done      <= 1'b0;
            r_pixel_cnt <= '0;
            r_short     <= 1'b0;
        end else begin
            r_valid <= w_keep;
            r_done  <= 1'b0;
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;

            if (bus.newFrame && (r_state == ACTIVE))
                r_short <= 1'b1;

            if (bus.iValid) begin
                if (w_keep) begin
                    r_data <= bus.iData;
                    r_x    <= w_x;
                    r_y    <= w_y;
                end
                r_pixel_cnt <= (w_first ? '0 : r_pixel_cnt) + {31'd0, w_keep};

                if (w_last) begin
                    r_state <= IDLE;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ACTIVE;
                    if (w_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= w_row + 16'd1;
                    end else begin
                        r_col <= w_col + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.oValid      = r_valid;
    assign bus.oData       = r_data;
    assign bus.oX          = r_x;
    assign bus.oY          = r_y;
    assign bus.oDone       = r_done;
    assign bus.oBusy       = (r_state == ACTIVE);
    assign bus.oPixelCnt   = r_pixel_cnt;
    assign bus.oShortFrame = r_short;
endmodule

// File: tb/tb_boundary_strip.sv
// Directed bench for boundary_strip: 4x3 interior with kernel 3 (6x5 padded)
// and a pass-through instance with kernel 1.
module tb_boundary_strip;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    boundary_strip_if bus3 ();
    boundary_strip_if bus1 ();

    boundary_strip #(.width(4), .height(3), .kernelSize(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    boundary_strip #(.width(4), .height(3), .kernelSize(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Captured output streams, stamped with the cycle count of the launching edge.
    logic [23:0] qd[$];
    logic [15:0] qx[$];
    logic [15:0] qy[$];
    int          qc[$];
    int          dc[$];
    logic [31:0] dp[$];
    logic [23:0] q1d[$];
    logic [15:0] q1x[$];
    logic [15:0] q1y[$];
    int          q1c[$];
    int          d1c[$];
    logic [31:0] d1p[$];

    always @(negedge clk) begin
        if (bus3.oValid) begin
            qd.push_back(bus3.oData);
            qx.push_back(bus3.oX);
            qy.push_back(bus3.oY);
            qc.push_back(cyc);
        end
        if (bus3.oDone) begin
            dc.push_back(cyc);
            dp.push_back(bus3.oPixelCnt);
        end
        if (bus1.oValid) begin
            q1d.push_back(bus1.oData);
            q1x.push_back(bus1.oX);
            q1y.push_back(bus1.oY);
            q1c.push_back(cyc);
        end
        if (bus1.oDone) begin
            d1c.push_back(cyc);
            d1p.push_back(bus1.oPixelCnt);
        end
    end

    // Padded beat indices that land inside the 4x3 interior (col 1..4, row 1..3 of 6x5).
    int kept[12] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};
    int beat_c[60];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        qd.delete(); qx.delete(); qy.delete(); qc.delete(); dc.delete(); dp.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat3(input logic [23:0] d, output int c);
        bus3.iValid = 1'b1;
        bus3.iData  = d;
        @(posedge clk);
        #1;
        c = cyc;
        bus3.iValid = 1'b0;
    endtask

    task automatic beat1(input logic [23:0] d, output int c);
        bus1.iValid = 1'b1;
        bus1.iData  = d;
        @(posedge clk);
        #1;
        c = cyc;
        bus1.iValid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int i = 0; i < 12; i++) begin
            if (base + i < qd.size()) begin
                check({tag, "_data"}, 32'(qd[base+i]), 32'(kept[i]));
                check({tag, "_x"}, 32'(qx[base+i]), 32'(i % 4));
                check({tag, "_y"}, 32'(qy[base+i]), 32'(i / 4));
            end
        end
    endtask

    task automatic check_full_frame(input string tag);
        check({tag, "_count"}, 32'(qd.size()), 32'd12);
        check_frame(tag, 0);
        check({tag, "_ndone"}, 32'(dc.size()), 32'd1);
        if (dc.size() > 0) begin
            check({tag, "_done_cyc"}, 32'(dc[0]), 32'(beat_c[29]));
            check({tag, "_done_cnt"}, dp[0], 32'd12);
        end
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus3.newFrame = 1'b0; bus3.iValid = 1'b0; bus3.iData = '0;
        bus1.newFrame = 1'b0; bus1.iValid = 1'b0; bus1.iData = '0;
        idle(3);
        reset = 1'b0;
        idle(1);

        check("rst_valid", 32'(bus3.oValid), 32'd0);
        check("rst_busy", 32'(bus3.oBusy), 32'd0);
        check("rst_done", 32'(bus3.oDone), 32'd0);
        check("rst_cnt", bus3.oPixelCnt, 32'd0);
        check("rst_short", 32'(bus3.oShortFrame), 32'd0);
        check("rst_data", 32'(bus3.oData), 32'd0);

        // 1: contiguous frame
        clear_q();
        for (int b = 0; b < 30; b++) begin
            beat3(24'(b), beat_c[b]);
            if (b == 5) check("t1_busy_mid", 32'(bus3.oBusy), 32'd1);
        end
        idle(2);
        check_full_frame("t1");
        if (qc.size() == 12) begin
            check("t1_first_lat", 32'(qc[0]), 32'(beat_c[7]));
            check("t1_last_lat", 32'(qc[11]), 32'(beat_c[22]));
        end
        check("t1_busy_end", 32'(bus3.oBusy), 32'd0);
        check("t1_cnt_hold", bus3.oPixelCnt, 32'd12);

        // 2: random gaps between beats
        clear_q();
        for (int b = 0; b < 30; b++) begin
            beat3(24'(b), beat_c[b]);
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);
        check_full_frame("t2");

        // 3: truncated frame, restart with newFrame on the same cycle as beat 0
        check("t3_short_pre", 32'(bus3.oShortFrame), 32'd0);
        clear_q();
        for (int b = 0; b < 11; b++) beat3(24'(b), c);
        idle(1);
        check("t3_partial_count", 32'(qd.size()), 32'd4);
        check("t3_partial_cnt", bus3.oPixelCnt, 32'd4);
        clear_q();
        bus3.newFrame = 1'b1;
        beat3(24'd0, beat_c[0]);
        bus3.newFrame = 1'b0;
        for (int b = 1; b < 30; b++) beat3(24'(b), beat_c[b]);
        idle(2);
        check("t3_short", 32'(bus3.oShortFrame), 32'd1);
        check_full_frame("t3");

        // 4: async reset in the middle of beat 15
        clear_q();
        for (int b = 0; b < 15; b++) beat3(24'(b), c);
        bus3.iValid = 1'b1;
        bus3.iData  = 24'd15;
        #2;
        reset = 1'b1;
        #1;
        check("t4_valid", 32'(bus3.oValid), 32'd0);
        check("t4_data", 32'(bus3.oData), 32'd0);
        check("t4_x", 32'(bus3.oX), 32'd0);
        check("t4_y", 32'(bus3.oY), 32'd0);
        check("t4_busy", 32'(bus3.oBusy), 32'd0);
        check("t4_cnt", bus3.oPixelCnt, 32'd0);
        check("t4_short", 32'(bus3.oShortFrame), 32'd0);
        bus3.iValid = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        clear_q();
        for (int b = 0; b < 30; b++) beat3(24'(b), beat_c[b]);
        idle(2);
        check_full_frame("t4");

        // 5: two frames back to back
        clear_q();
        for (int b = 0; b < 60; b++) beat3(24'(b % 30), beat_c[b]);
        idle(2);
        check("t5_count", 32'(qd.size()), 32'd24);
        check_frame("t5a", 0);
        check_frame("t5b", 12);
        check("t5_ndone", 32'(dc.size()), 32'd2);
        if (dc.size() == 2) begin
            check("t5_done0", 32'(dc[0]), 32'(beat_c[29]));
            check("t5_done1", 32'(dc[1]), 32'(beat_c[59]));
            check("t5_spacing", 32'(dc[1] - dc[0]), 32'd30);
            check("t5_cnt1", dp[1], 32'd12);
        end

        // 6: kernelSize 1 passes every beat
        for (int b = 0; b < 12; b++) beat1(24'(100 + b), beat_c[b]);
        idle(2);
        check("t6_count", 32'(q1d.size()), 32'd12);
        for (int b = 0; b < 12; b++) begin
            if (b < q1d.size()) begin
                check("t6_data", 32'(q1d[b]), 32'(100 + b));
                check("t6_x", 32'(q1x[b]), 32'(b % 4));
                check("t6_y", 32'(q1y[b]), 32'(b / 4));
                check("t6_lat", 32'(q1c[b]), 32'(beat_c[b]));
            end
        end
        check("t6_ndone", 32'(d1c.size()), 32'd1);
        if (d1c.size() > 0) begin
            check("t6_done_cyc", 32'(d1c[0]), 32'(beat_c[11]));
            check("t6_done_cnt", d1p[0], 32'd12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
